// File: rtl/usr_reg.sv
// usr_reg: parametrised universal shift register with serial/parallel I/O and framing.
//   Operations: hold, shift right, shift left, parallel load. A shift counter pulses
//   frame_done (registered) on every WIDTH-th shift, so the block serves as SIPO/PISO
//   framing for serial links as well as a plain parallel register.
//   Optional feature macro: USR_ROTATE_EN (rot=1 turns shifts into rotates).
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   clr        synchronous clear of dout/cnt/frame_done (highest priority after reset)
//   en         operation enable (0 = hold)
//   mode       00 hold, 01 shift right, 10 shift left, 11 parallel load
//   din        parallel load data
//   sin_r      serial in at MSB (shift right)
//   sin_l      serial in at LSB (shift left)
//   rot        rotate select (only meaningful with USR_ROTATE_EN)
//   dout       register contents
//   sout_r     dout[0]
//   sout_l     dout[WIDTH-1]
//   cnt        shifts since last load/clear, modulo WIDTH
//   frame_done one-cycle pulse on the WIDTH-th shift
module usr_reg #(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned CW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] din,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic             rot,
   output logic [WIDTH-1:0] dout,
   output logic             sout_r,
   output logic             sout_l,
   output logic [CW-1:0]    cnt,
   output logic             frame_done
);

   localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

   logic [WIDTH-1:0] dout_q, dout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fd_q, fd_d;
   logic             msb_in, lsb_in;

`ifdef USR_ROTATE_EN
   // Rotation recirculates the bit leaving the opposite end.
   assign msb_in = rot ? dout_q[0]       : sin_r;
   assign lsb_in = rot ? dout_q[WIDTH-1] : sin_l;
`else
   // rot kept on the port list for a stable interface; intentionally unused.
   logic unused_rot;
   assign unused_rot = rot;
   assign msb_in     = sin_r;
   assign lsb_in     = sin_l;
`endif

   always_comb begin
      dout_d = dout_q;
      cnt_d  = cnt_q;
      fd_d   = 1'b0;
      if (clr) begin
         dout_d = '0;
         cnt_d  = '0;
      end else if (en) begin
         unique case (mode)
            2'b00: ;
            2'b01: dout_d = {msb_in, dout_q[WIDTH-1:1]};
            2'b10: dout_d = {dout_q[WIDTH-2:0], lsb_in};
            2'b11: begin
               dout_d = din;
               cnt_d  = '0;
            end
         endcase
         // Both shift directions share one counter; direction changes do not restart it.
         if (mode == 2'b01 || mode == 2'b10) begin
            if (cnt_q == CntLast) begin
               cnt_d = '0;
               fd_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout_q <= '0;
         cnt_q  <= '0;
         fd_q   <= 1'b0;
      end else begin
         dout_q <= dout_d;
         cnt_q  <= cnt_d;
         fd_q   <= fd_d;
      end
   end

   assign dout       = dout_q;
   assign sout_r     = dout_q[0];
   assign sout_l     = dout_q[WIDTH-1];
   assign cnt        = cnt_q;
   assign frame_done = fd_q;

endmodule
